io_store_port: RTL and testbench
================================

Name: io_store_port

Overview:
- Memory-mapped output port downstream of the CPU memory interface.
- Snoops the CPU store path: write strobe, address-mux output and store-data-mux output.
- Captures every store whose address falls in the I/O window into a FIFO.
- Drains the FIFO to an external sink (display/UART driver) over a valid/ready handshake, giving the CPU its bus output without stalling the core.

Parameters:
- IO_BASE, 16'hFF00, base address of I/O window.
- IO_MASK, 16'hFF00, address bits compared against IO_BASE.
- DEPTH, 8, FIFO entries; power of two, ≥2.
- CW, 4, count width = log2(DEPTH)+1.

Ports:
- CLK  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- MemWrite  in  1  CPU store strobe, one cycle per store.
- ADDR  in  16  CPU memory address.
- wdata  in  16  CPU store data.
- out_data  out  16  head-of-FIFO word.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  sink accepts word.
- count  out  CW  words currently stored.
- full  out  1  count == DEPTH.
- ovf  out  1  sticky: at least one store dropped.
- drop_cnt  out  8  saturating count of dropped stores.
- clr_ovf  in  1  synchronous clear of ovf and drop_cnt.

Behaviour:
- Reset (reset=0, asynchronous):
  - Read and write pointers = 0, count = 0.
  - out_valid = 0, out_data = 0, full = 0, ovf = 0, drop_cnt = 0.
  - Storage contents are don't-care.
  - Reset mid-operation discards all queued words. The deassertion edge is synchronised internally, so the first push can be accepted on the second rising edge after release.
- Hit: hit = MemWrite && ((ADDR & IO_MASK) == (IO_BASE & IO_MASK)). Non-hit stores are ignored and do not change any state.
- Push:
  - On a hit edge with space (count < DEPTH, or a pop in the same cycle), write wdata at wr_ptr and increment wr_ptr modulo DEPTH.
  - On a hit with count == DEPTH and no pop: drop the word, set ovf = 1, and increment drop_cnt, saturating at 8'hFF.
- Pop: out_valid && out_ready at a rising edge. rd_ptr increments modulo DEPTH.
- Simultaneous push and pop:
  - count is unchanged.
  - When full, the push is accepted because the pop frees the slot.
  - When count == 1, the new word becomes the head on the next cycle.
- No bypass: a word pushed at edge N is visible on out_data/out_valid after edge N (combinational read of storage at rd_ptr). Push-to-valid latency is 1 cycle.
- out_valid = (count != 0). out_data equals mem[rd_ptr] when valid and holds its last value when empty (not required to be 0 after the first use).
- Sink protocol:
  - out_data is stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a pop.
  - Popping when empty is impossible by construction.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. count distinguishes full from empty.
- clr_ovf:
  - Takes effect at the next edge: ovf = 0, drop_cnt = 0.
  - If a drop occurs in the same cycle, the clear wins for drop_cnt (result 1) and ovf ends at 1.
- full is registered together with count; there are no combinational paths from MemWrite to full.

Test Plan:
- Reset, then store 16'h1234 to FF00 with out_ready=0 → after 1 edge: count=1, out_valid=1, out_data=16'h1234, ovf=0.
- Stores to 0x0010 and FE00 with MemWrite=1 → count stays 0 and out_valid stays 0. Store to FF7F → captured.
- Ten hit stores 0..9 with out_ready=0 → count=8, full=1, ovf=1, drop_cnt=2. Then raise out_ready → words 0..7 drain in order, one per cycle, and out_valid falls after word 7.
- Full FIFO with a hit store of 16'hAAAA and a pop in the same cycle → count stays 8, drop_cnt unchanged, 16'hAAAA emerges as the eighth word after the head.
- Continuous pushes and pops over 20 cycles, crossing pointer wrap twice → output sequence equals input sequence and count stays 1.
- Assert reset=0 mid-drain with count=5 → out_valid=0 and count=0 immediately, without waiting for an edge. Pulse clr_ovf after an overflow → ovf=0 and drop_cnt=0 next cycle.

Source files
------------

// File: rtl/io_store_port.sv
// Memory-mapped output port: captures CPU stores that hit the I/O window into a
// small FIFO and drains them to an external sink over valid/ready.
module io_store_port #(
  parameter logic [15:0] IO_BASE = 16'hFF00,
  parameter logic [15:0] IO_MASK = 16'hFF00,
  parameter int          DEPTH   = 8,
  parameter int          CW      = 4
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          MemWrite,
  input  logic [15:0]   ADDR,
  input  logic [15:0]   wdata,
  output logic [15:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          ovf,
  output logic [7:0]    drop_cnt,
  input  logic          clr_ovf
);

  localparam int AW = $clog2(DEPTH);

  logic          rst_sync_q;
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    drop_q, drop_d;
  logic [15:0]   last_q, last_d;
  logic          hit, push, pop, drop;

  // Assertion is immediate; release reaches the datapath one edge later.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) rst_sync_q <= 1'b0;
    else        rst_sync_q <= 1'b1;
  end

  assign hit  = MemWrite && ((ADDR & IO_MASK) == (IO_BASE & IO_MASK));
  assign pop  = out_valid && out_ready;
  assign push = hit && (!full_q || pop);
  assign drop = hit && full_q && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      last_d   = mem_q[rd_ptr_q];
    end
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    full_d = (count_d == CW'(DEPTH));
    // A drop coinciding with a clear leaves exactly one recorded drop.
    if (clr_ovf) begin
      ovf_d  = drop;
      drop_d = drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= 8'd0;
      last_q   <= 16'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      last_q   <= last_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : last_q;
  assign count     = count_q;
  assign full      = full_q;
  assign ovf       = ovf_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_io_store_port.sv
// Randomized and directed bench for io_store_port against a queue-based model.
module tb_io_store_port;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [15:0] ADDR = 16'd0;
  logic [15:0] wdata = 16'd0;
  logic        out_ready = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic [3:0]  count;
  logic        full;
  logic        ovf;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad = 0;

  logic [15:0] mq[$];
  logic [15:0] m_last = 16'd0;
  bit          m_ovf = 1'b0;
  int          m_drop = 0;
  bit          model_en = 1'b0;

  io_store_port dut (
    .CLK(CLK), .reset(reset), .MemWrite(MemWrite), .ADDR(ADDR), .wdata(wdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .ovf(ovf), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pop the head first, then a hit store is accepted if a slot is free.
  always @(posedge CLK) begin
    if (model_en) begin
      bit hit, pop, dropped;
      hit = MemWrite && ((ADDR & 16'hFF00) == 16'hFF00);
      pop = (mq.size() != 0) && out_ready;
      dropped = 1'b0;
      if (pop) m_last = mq.pop_front();
      if (hit) begin
        if (mq.size() < 8) mq.push_back(wdata);
        else dropped = 1'b1;
      end
      if (clr_ovf) begin
        m_ovf = dropped;
        m_drop = dropped ? 1 : 0;
      end else if (dropped) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
      #1;
      chk("count", 32'(count), 32'(mq.size()));
      chk("full", 32'(full), 32'(mq.size() == 8));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("out_data", 32'(out_data), 32'((mq.size() != 0) ? mq[0] : m_last));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    end
  end

  // Drive one cycle of inputs; returns at the following negedge.
  task automatic step(input bit mw, input logic [15:0] a, input logic [15:0] d,
                      input bit rdy, input bit clr);
    MemWrite = mw; ADDR = a; wdata = d; out_ready = rdy; clr_ovf = clr;
    @(negedge CLK);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 16'h0000, 16'h0000, rdy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) idle(1'b1);
  endtask

  task automatic restart();
    @(negedge CLK);
    reset = 1'b1;
    repeat (3) @(negedge CLK);
    model_en = 1'b1;
  endtask

  initial begin
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    restart();

    step(1'b1, 16'hFF00, 16'h1234, 1'b0, 1'b0);
    chk("first_count", 32'(count), 32'd1);
    chk("first_data", 32'(out_data), 32'h1234);
    chk("first_ovf", 32'(ovf), 32'd0);
    drain();

    step(1'b1, 16'h0010, 16'h5555, 1'b0, 1'b0);
    step(1'b1, 16'hFE00, 16'h6666, 1'b0, 1'b0);
    chk("miss_count", 32'(count), 32'd0);
    step(1'b1, 16'hFF7F, 16'h7777, 1'b0, 1'b0);
    chk("ff7f_count", 32'(count), 32'd1);
    drain();

    for (int i = 0; i < 10; i++) step(1'b1, 16'hFF10, 16'(i), 1'b0, 1'b0);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_flag", 32'(ovf), 32'd1);
    chk("ovf_drop", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 8; i++) begin
      chk("drain_word", 32'(out_data), 32'(i));
      idle(1'b1);
    end
    chk("drain_empty", 32'(out_valid), 32'd0);
    chk("drain_hold", 32'(out_data), 32'd7);

    for (int i = 0; i < 8; i++) step(1'b1, 16'hFF20, 16'h0100 + 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'hFF20, 16'hAAAA, 1'b1, 1'b0);
    chk("fullpp_count", 32'(count), 32'd8);
    chk("fullpp_drop", 32'(drop_cnt), 32'd2);
    for (int i = 1; i < 8; i++) begin
      chk("fullpp_word", 32'(out_data), 32'h0100 + 32'(i));
      idle(1'b1);
    end
    chk("fullpp_aaaa", 32'(out_data), 32'hAAAA);
    drain();

    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("clr_ovf", 32'(ovf), 32'd0);
    chk("clr_drop", 32'(drop_cnt), 32'd0);

    for (int i = 0; i < 9; i++) step(1'b1, 16'hFF00, 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'hFF00, 16'hBEEF, 1'b0, 1'b1);
    chk("clrdrop_drop", 32'(drop_cnt), 32'd1);
    chk("clrdrop_ovf", 32'(ovf), 32'd1);
    for (int i = 0; i < 260; i++) step(1'b1, 16'hFFFF, 16'(i), 1'b0, 1'b0);
    chk("sat_drop", 32'(drop_cnt), 32'hFF);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
    drain();

    step(1'b1, 16'hFF00, 16'hC000, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) step(1'b1, 16'hFF01, 16'hC000 + 16'(i), 1'b1, 1'b0);
    chk("stream_count", 32'(count), 32'd1);
    chk("stream_head", 32'(out_data), 32'hC014);
    drain();

    for (int i = 0; i < 600; i++) begin
      logic [15:0] a;
      a = 16'($urandom);
      if ($urandom_range(0, 3) != 0) a[15:8] = 8'hFF;
      step(1'($urandom_range(0, 1)), a, 16'($urandom),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 30) == 0));
    end
    drain();

    for (int i = 0; i < 6; i++) step(1'b1, 16'hFF00, 16'hD000 + 16'(i), 1'b0, 1'b0);
    idle(1'b1);
    chk("pre_rst_count", 32'(count), 32'd5);
    model_en = 1'b0;
    MemWrite = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    mq.delete();
    m_last = 16'd0; m_ovf = 1'b0; m_drop = 0;
    restart();
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), {8'hFF, 8'($urandom)}, 16'($urandom),
           1'($urandom_range(0, 1)), 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, limit 200000");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
